// File: rtl/fuzzy_mmio_pkg.sv
// Shared constants, sequencer state type and default seed values for the
// fuzzy-controller MMIO register bank.
package fuzzy_mmio_pkg;

  // Register map
  localparam int STATUS   = 'h00;
  localparam int CTRL     = 'h01;
  localparam int GOUT     = 'h02;
  localparam int ID       = 'h03;
  localparam int X_BASE   = 'h08;
  localparam int MF_BASE  = 'h10;
  localparam int G_BASE   = 'h80;
  localparam int EST_BASE = 'hF0;

  // CTRL bit positions
  localparam int CTRL_START    = 0;
  localparam int CTRL_REG_MODE = 1;
  localparam int CTRL_DT_MODE  = 2;
  localparam int CTRL_INIT     = 3;
  localparam int CTRL_COMMIT   = 4;
  localparam int CTRL_IE       = 5;

  // STATUS bit positions
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_OVR  = 2;
  localparam int ST_ADDR = 3;
  localparam int ST_SEQ  = 4;

  // Estimator parameter defaults
  localparam int ALPHA_DEFAULT = 32;
  localparam int KDT_DEFAULT   = 3;
  localparam int DMAX_DEFAULT  = 64;

  typedef enum logic [3:0] {
    SEQ_IDLE    = 4'd0,
    SEQ_CMT     = 4'd1,
    SEQ_INIT_P  = 4'd2,
    SEQ_START_P = 4'd3
  } seq_state_t;

  // Evenly spread trapezoids per term, nudged slightly per input
  function automatic logic [7:0] mf_default(input int i, input int t, input int p);
    logic [31:0] v;
    v = 32'(t * 64 + p * 32 + i * 8);
    return v[7:0];
  endfunction

  // Rising ramp of rule singletons
  function automatic logic [7:0] g_default(input int r);
    logic [31:0] v;
    v = 32'(r * 28 + 10);
    return v[7:0];
  endfunction

  // True when a lies in [base, base+n)
  function automatic logic in_range(input int a, input int base, input int n);
    return (a >= base) && (a < base + n);
  endfunction

endpackage

// File: rtl/fuzzy_mmio_seq.sv
// Command sequencer: gates the shadow->active commit, then emits the
// optional init and start pulses; flags commands that arrive too early.
module fuzzy_mmio_seq
  import fuzzy_mmio_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd,
  input  logic       start_req,
  input  logic       init_req,
  input  logic       busy,
  output logic       commit,
  output logic       overrun,
  output logic       start_pulse,
  output logic       init_pulse,
  output seq_state_t state
);

  seq_state_t state_next;
  logic       start_pend;
  logic       start_pend_next;

  // State register plus the start request remembered across the init pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEQ_IDLE;
      start_pend <= 1'b0;
    end else begin
      state      <= state_next;
      start_pend <= start_pend_next;
    end
  end

  // Next state, commit strobe, pulses (decoded from state) and overrun
  always_comb begin
    state_next      = state;
    start_pend_next = start_pend;
    commit          = 1'b0;
    overrun         = 1'b0;
    start_pulse     = 1'b0;
    init_pulse      = 1'b0;
    case (state)
      SEQ_IDLE: begin
        if (cmd) begin
          if (busy) begin
            overrun = 1'b1;
          end else begin
            commit          = 1'b1;
            start_pend_next = start_req;
            if (init_req)       state_next = SEQ_INIT_P;
            else if (start_req) state_next = SEQ_START_P;
            else                state_next = SEQ_CMT;
          end
        end
      end
      SEQ_CMT: begin
        overrun    = cmd;
        state_next = SEQ_IDLE;
      end
      SEQ_INIT_P: begin
        overrun    = cmd;
        init_pulse = 1'b1;
        state_next = start_pend ? SEQ_START_P : SEQ_IDLE;
      end
      SEQ_START_P: begin
        overrun     = cmd;
        start_pulse = 1'b1;
        state_next  = SEQ_IDLE;
      end
      default: state_next = SEQ_IDLE;
    endcase
  end

endmodule

// File: rtl/fuzzy_mmio_regbank.sv
// Host-facing register bank for the fuzzy core: shadow/active configuration
// with atomic commit, sticky clear-on-read status and registered readback.
module fuzzy_mmio_regbank
  import fuzzy_mmio_pkg::*;
#(
  parameter int DW     = 8,
  parameter int AW     = 8,
  parameter int N_IN   = 2,
  parameter int N_TERM = 3,
  parameter int N_RULE = 9,
  parameter int DT_IDX = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cs,
  input  logic                         rd,
  input  logic                         wr,
  input  logic [AW-1:0]                addr,
  input  logic [DW-1:0]                wdata,
  output logic [DW-1:0]                rdata,
  output logic                         rvalid,
  output logic                         start_pulse,
  output logic                         init_pulse,
  output logic                         reg_mode,
  output logic                         dt_mode,
  output logic [N_IN*DW-1:0]           x_act,
  output logic [N_IN*N_TERM*4*DW-1:0]  mf_act,
  output logic [N_RULE*DW-1:0]         g_act,
  output logic [DW-1:0]                alpha,
  output logic [DW-1:0]                k_dt,
  output logic [DW-1:0]                d_max,
  input  logic [DW-1:0]                dt_mon,
  input  logic [DW-1:0]                g_out,
  input  logic                         busy,
  input  logic                         valid,
  output logic                         irq
);

  localparam int N_MF = N_IN * N_TERM * 4;

  logic [DW-1:0] x_sh   [N_IN];
  logic [DW-1:0] x_ar   [N_IN];
  logic [DW-1:0] mf_sh  [N_MF];
  logic [DW-1:0] mf_ar  [N_MF];
  logic [DW-1:0] g_sh   [N_RULE];
  logic [DW-1:0] g_ar   [N_RULE];
  logic [DW-1:0] est_sh [3];
  logic [DW-1:0] est_ar [3];
  logic          rm_sh, dt_sh, rm_ar, dt_ar, ie;
  logic          done, err_ovr, err_addr;

  int            addr_int;
  logic          wr_en, rd_en, wr_ok, wr_bad, status_rd, cmd;
  logic          commit, overrun;
  logic [DW-1:0] rd_mux;
  seq_state_t    seq_state;

  assign addr_int  = int'(addr);
  assign wr_en     = cs & wr;
  assign rd_en     = cs & rd;
  assign status_rd = rd_en && (addr_int == STATUS);
  assign cmd       = wr_en && (addr_int == CTRL) &&
                     (wdata[CTRL_START] | wdata[CTRL_INIT] | wdata[CTRL_COMMIT]);

  fuzzy_mmio_seq u_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd         (cmd),
    .start_req   (wdata[CTRL_START]),
    .init_req    (wdata[CTRL_INIT]),
    .busy        (busy),
    .commit      (commit),
    .overrun     (overrun),
    .start_pulse (start_pulse),
    .init_pulse  (init_pulse),
    .state       (seq_state)
  );

  // Anything outside the writable windows is a bad write (RO regs included)
  always_comb begin
    wr_ok  = (addr_int == CTRL) ||
             in_range(addr_int, X_BASE, N_IN) ||
             in_range(addr_int, MF_BASE, N_MF) ||
             in_range(addr_int, G_BASE, N_RULE) ||
             in_range(addr_int, EST_BASE, 3);
    wr_bad = wr_en && !wr_ok;
  end

  // Readback mux; the estimator-driven input shows live dt_mon when active
  always_comb begin
    rd_mux = '0;
    if (addr_int == STATUS) begin
      rd_mux[ST_BUSY]       = busy;
      rd_mux[ST_DONE]       = done;
      rd_mux[ST_OVR]        = err_ovr;
      rd_mux[ST_ADDR]       = err_addr;
      rd_mux[ST_SEQ +: 4]   = seq_state;
    end
    if (addr_int == CTRL) begin
      rd_mux[CTRL_REG_MODE] = rm_sh;
      rd_mux[CTRL_DT_MODE]  = dt_sh;
      rd_mux[CTRL_IE]       = ie;
    end
    if (addr_int == GOUT) rd_mux = g_out;
    if (addr_int == ID)   rd_mux = DW'({4'(N_IN), 4'(N_TERM)});
    for (int k = 0; k < N_IN; k++)
      if (addr_int == X_BASE + k)
        rd_mux = (k == DT_IDX && dt_ar) ? dt_mon : x_sh[k];
    for (int k = 0; k < N_MF; k++)
      if (addr_int == MF_BASE + k) rd_mux = mf_sh[k];
    for (int k = 0; k < N_RULE; k++)
      if (addr_int == G_BASE + k) rd_mux = g_sh[k];
    for (int k = 0; k < 3; k++)
      if (addr_int == EST_BASE + k) rd_mux = est_sh[k];
  end

  // Shadow registers and CTRL mode/ie bits: host writes always land here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_IN; k++) x_sh[k] <= '0;
      for (int i = 0; i < N_IN; i++)
        for (int t = 0; t < N_TERM; t++)
          for (int p = 0; p < 4; p++)
            mf_sh[(i * N_TERM + t) * 4 + p] <= DW'(mf_default(i, t, p));
      for (int r = 0; r < N_RULE; r++) g_sh[r] <= DW'(g_default(r));
      est_sh[0] <= DW'(ALPHA_DEFAULT);
      est_sh[1] <= DW'(KDT_DEFAULT);
      est_sh[2] <= DW'(DMAX_DEFAULT);
      rm_sh     <= 1'b1;
      dt_sh     <= 1'b1;
      ie        <= 1'b0;
    end else if (wr_en) begin
      for (int k = 0; k < N_IN; k++)
        if (addr_int == X_BASE + k && !(k == DT_IDX && dt_sh)) x_sh[k] <= wdata;
      for (int k = 0; k < N_MF; k++)
        if (addr_int == MF_BASE + k) mf_sh[k] <= wdata;
      for (int k = 0; k < N_RULE; k++)
        if (addr_int == G_BASE + k) g_sh[k] <= wdata;
      for (int k = 0; k < 3; k++)
        if (addr_int == EST_BASE + k) est_sh[k] <= wdata;
      if (addr_int == CTRL) begin
        rm_sh <= wdata[CTRL_REG_MODE];
        dt_sh <= wdata[CTRL_DT_MODE];
        ie    <= wdata[CTRL_IE];
      end
    end
  end

  // Active set: only changes on an accepted commit (modes come from that same CTRL word)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_IN; k++) x_ar[k] <= '0;
      for (int i = 0; i < N_IN; i++)
        for (int t = 0; t < N_TERM; t++)
          for (int p = 0; p < 4; p++)
            mf_ar[(i * N_TERM + t) * 4 + p] <= DW'(mf_default(i, t, p));
      for (int r = 0; r < N_RULE; r++) g_ar[r] <= DW'(g_default(r));
      est_ar[0] <= DW'(ALPHA_DEFAULT);
      est_ar[1] <= DW'(KDT_DEFAULT);
      est_ar[2] <= DW'(DMAX_DEFAULT);
      rm_ar     <= 1'b1;
      dt_ar     <= 1'b1;
    end else if (commit) begin
      for (int k = 0; k < N_IN; k++)   x_ar[k]   <= x_sh[k];
      for (int k = 0; k < N_MF; k++)   mf_ar[k]  <= mf_sh[k];
      for (int k = 0; k < N_RULE; k++) g_ar[k]   <= g_sh[k];
      for (int k = 0; k < 3; k++)      est_ar[k] <= est_sh[k];
      rm_ar <= wdata[CTRL_REG_MODE];
      dt_ar <= wdata[CTRL_DT_MODE];
    end
  end

  // Sticky flags: a new event in the same cycle as a STATUS read wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      err_ovr  <= 1'b0;
      err_addr <= 1'b0;
    end else begin
      if (valid)          done <= 1'b1;
      else if (status_rd) done <= 1'b0;
      if (overrun)        err_ovr <= 1'b1;
      else if (status_rd) err_ovr <= 1'b0;
      if (wr_bad)         err_addr <= 1'b1;
      else if (status_rd) err_addr <= 1'b0;
    end
  end

  // Registered read port, one cycle of latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) rdata <= rd_mux;
    end
  end

  for (genvar k = 0; k < N_IN; k++) begin : g_x_flat
    assign x_act[k*DW +: DW] = x_ar[k];
  end
  for (genvar k = 0; k < N_MF; k++) begin : g_mf_flat
    assign mf_act[k*DW +: DW] = mf_ar[k];
  end
  for (genvar k = 0; k < N_RULE; k++) begin : g_g_flat
    assign g_act[k*DW +: DW] = g_ar[k];
  end

  assign alpha    = est_ar[0];
  assign k_dt     = est_ar[1];
  assign d_max    = est_ar[2];
  assign reg_mode = rm_ar;
  assign dt_mode  = dt_ar;
  assign irq      = done & ie;

endmodule

// File: tb/tb_fuzzy_mmio_regbank.sv
// Directed and randomized checks of the MMIO register bank against an
// address-map level model of shadow/active registers and sticky flags.
module tb_fuzzy_mmio_regbank;
  import fuzzy_mmio_pkg::*;

  localparam int N_IN   = 2;
  localparam int N_TERM = 3;
  localparam int N_RULE = 9;
  localparam int DT_IDX = 1;
  localparam int N_MF   = N_IN * N_TERM * 4;

  logic                 clk = 1'b0;
  logic                 rst_n, cs, rd, wr, busy, valid;
  logic [7:0]           addr, wdata, dt_mon, g_out;
  logic [7:0]           rdata, alpha, k_dt, d_max;
  logic                 rvalid, start_pulse, init_pulse, reg_mode, dt_mode, irq;
  logic [N_IN*8-1:0]    x_act;
  logic [N_MF*8-1:0]    mf_act;
  logic [N_RULE*8-1:0]  g_act;

  int nvec = 0;
  int nerr = 0;

  // Reference model state
  logic [7:0] m_x_sh[N_IN], m_x_ar[N_IN], m_mf_sh[N_MF], m_mf_ar[N_MF];
  logic [7:0] m_g_sh[N_RULE], m_g_ar[N_RULE], m_est_sh[3], m_est_ar[3];
  logic       m_rm_sh, m_dt_sh, m_rm_ar, m_dt_ar, m_ie, m_done, m_ovr, m_addr;

  always #5 clk = ~clk;

  fuzzy_mmio_regbank #(
    .DW(8), .AW(8), .N_IN(N_IN), .N_TERM(N_TERM), .N_RULE(N_RULE), .DT_IDX(DT_IDX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .rd(rd), .wr(wr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .start_pulse(start_pulse),
    .init_pulse(init_pulse), .reg_mode(reg_mode), .dt_mode(dt_mode),
    .x_act(x_act), .mf_act(mf_act), .g_act(g_act), .alpha(alpha), .k_dt(k_dt),
    .d_max(d_max), .dt_mon(dt_mon), .g_out(g_out), .busy(busy), .valid(valid),
    .irq(irq)
  );

  // One comparison with an immediate assertion
  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk); cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk); cs = 1'b0; wr = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
    @(negedge clk); cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk); cs = 1'b0; rd = 1'b0;
    check_output({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check_output(tag, 32'(rdata), 32'(exp));
  endtask

  // CTRL write, then pulse samples in cycles N+1, N+2, N+3
  task automatic ctrl_cmd(input logic [7:0] wd, output logic [2:0] sp, output logic [2:0] ip);
    @(negedge clk); cs = 1'b1; wr = 1'b1; addr = 8'h01; wdata = wd;
    @(posedge clk); #1; cs = 1'b0; wr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sp[c] = start_pulse;
      ip[c] = init_pulse;
      if (c < 2) begin
        @(posedge clk); #1;
      end
    end
  endtask

  function automatic void reset_model();
    for (int k = 0; k < N_IN; k++) begin m_x_sh[k] = 8'h00; m_x_ar[k] = 8'h00; end
    for (int i = 0; i < N_IN; i++)
      for (int t = 0; t < N_TERM; t++)
        for (int p = 0; p < 4; p++) begin
          m_mf_sh[(i*N_TERM+t)*4+p] = mf_default(i, t, p);
          m_mf_ar[(i*N_TERM+t)*4+p] = mf_default(i, t, p);
        end
    for (int r = 0; r < N_RULE; r++) begin m_g_sh[r] = g_default(r); m_g_ar[r] = g_default(r); end
    m_est_sh[0] = 8'd32; m_est_sh[1] = 8'd3; m_est_sh[2] = 8'd64;
    m_est_ar = m_est_sh;
    m_rm_sh = 1'b1; m_dt_sh = 1'b1; m_rm_ar = 1'b1; m_dt_ar = 1'b1;
    m_ie = 1'b0; m_done = 1'b0; m_ovr = 1'b0; m_addr = 1'b0;
  endfunction

  function automatic logic [7:0] exp_read(input int a);
    if (a == 0) return {4'h0, m_addr, m_ovr, m_done, 1'b0};
    if (a == 1) return {2'b00, m_ie, 2'b00, m_dt_sh, m_rm_sh, 1'b0};
    if (a == 2) return g_out;
    if (a == 3) return {4'(N_IN), 4'(N_TERM)};
    if (a >= 8 && a < 8 + N_IN) return (a - 8 == DT_IDX && m_dt_ar) ? dt_mon : m_x_sh[a-8];
    if (a >= 16 && a < 16 + N_MF) return m_mf_sh[a-16];
    if (a >= 128 && a < 128 + N_RULE) return m_g_sh[a-128];
    if (a >= 240 && a < 243) return m_est_sh[a-240];
    return 8'h00;
  endfunction

  function automatic int pick_addr(input int region);
    int bad[15];
    bad = '{0, 2, 3, 4, 5, 6, 7, 8 + N_IN, 15, 16 + N_MF, 127, 128 + N_RULE, 239, 243, 255};
    case (region)
      0: return 8 + int'($urandom_range(0, N_IN - 1));
      1: return 16 + int'($urandom_range(0, N_MF - 1));
      2: return 128 + int'($urandom_range(0, N_RULE - 1));
      3: return 240 + int'($urandom_range(0, 2));
      default: return bad[$urandom_range(0, 14)];
    endcase
  endfunction

  task automatic check_active(input string tag);
    for (int k = 0; k < N_IN; k++)   check_output({tag, "_x"},   32'(x_act[k*8 +: 8]),  32'(m_x_ar[k]));
    for (int k = 0; k < N_MF; k++)   check_output({tag, "_mf"},  32'(mf_act[k*8 +: 8]), 32'(m_mf_ar[k]));
    for (int k = 0; k < N_RULE; k++) check_output({tag, "_g"},   32'(g_act[k*8 +: 8]),  32'(m_g_ar[k]));
    check_output({tag, "_alpha"}, 32'(alpha), 32'(m_est_ar[0]));
    check_output({tag, "_kdt"},   32'(k_dt),  32'(m_est_ar[1]));
    check_output({tag, "_dmax"},  32'(d_max), 32'(m_est_ar[2]));
    check_output({tag, "_rm"},    32'(reg_mode), 32'(m_rm_ar));
    check_output({tag, "_dt"},    32'(dt_mode),  32'(m_dt_ar));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] sp, ip;
    int         a, op;
    logic [7:0] d;

    rst_n = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; busy = 1'b0; valid = 1'b0;
    addr = 8'h00; wdata = 8'h00; dt_mon = 8'h5A; g_out = 8'hA7;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    reset_model();
    check_output("rst_rvalid", 32'(rvalid), 32'd0);
    check_output("rst_irq", 32'(irq), 32'd0);
    check_output("rst_start", 32'(start_pulse), 32'd0);
    check_output("rst_init", 32'(init_pulse), 32'd0);
    check_active("rst");
    read_check("rst_status", 8'h00, 8'h00);
    read_check("rst_ctrl", 8'h01, 8'h06);
    read_check("id", 8'h03, 8'h23);
    read_check("gout", 8'h02, 8'hA7);
    read_check("unmapped_rd", 8'h40, 8'h00);
    read_check("status_after_unmapped_rd", 8'h00, 8'h00);
    read_check("g0_shadow", 8'h80, g_default(0));

    // Commit + start at busy=0
    bus_write(8'h80, 8'd77);
    ctrl_cmd(8'h01, sp, ip);
    check_output("start_only_sp", 32'(sp), 32'b001);
    check_output("start_only_ip", 32'(ip), 32'b000);
    check_output("g0_committed", 32'(g_act[7:0]), 32'd77);
    check_output("rm_committed", 32'(reg_mode), 32'd0);

    // Command while busy is dropped
    busy = 1'b1;
    bus_write(8'h10, 8'h55);
    ctrl_cmd(8'h01, sp, ip);
    check_output("busy_sp", 32'(sp), 32'b000);
    check_output("busy_mf0", 32'(mf_act[7:0]), 32'(mf_default(0, 0, 0)));
    read_check("busy_mf0_shadow", 8'h10, 8'h55);
    read_check("busy_status1", 8'h00, 8'h05);
    read_check("busy_status2", 8'h00, 8'h01);
    busy = 1'b0;

    // Init + start
    ctrl_cmd(8'h09, sp, ip);
    check_output("init_start_ip", 32'(ip), 32'b001);
    check_output("init_start_sp", 32'(sp), 32'b010);
    check_output("init_start_mf0", 32'(mf_act[7:0]), 32'h55);
    read_check("init_start_status", 8'h00, 8'h00);

    // Back-to-back command while the sequencer is busy
    @(negedge clk); cs = 1'b1; wr = 1'b1; addr = 8'h01; wdata = 8'h01;
    @(negedge clk);
    @(negedge clk); cs = 1'b0; wr = 1'b0;
    read_check("seq_ovr_status", 8'h00, 8'h04);

    // Read and write in the same cycle return the old value
    bus_write(8'h08, 8'h11);
    @(negedge clk); cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 8'h08; wdata = 8'h22;
    @(negedge clk); cs = 1'b0; rd = 1'b0; wr = 1'b0;
    check_output("rdwr_old", 32'(rdata), 32'h11);
    read_check("rdwr_new", 8'h08, 8'h22);

    // Internal dT estimator selected
    ctrl_cmd(8'h14, sp, ip);
    check_output("dtm_active", 32'(dt_mode), 32'd1);
    bus_write(8'h09, 8'h33);
    read_check("dtm_x1_mon", 8'h09, 8'h5A);
    read_check("dtm_no_err", 8'h00, 8'h00);
    bus_write(8'h55, 8'h12);
    read_check("bad_addr_status", 8'h00, 8'h08);
    ctrl_cmd(8'h10, sp, ip);
    read_check("dtm_x1_untouched", 8'h09, 8'h00);
    check_output("dtm_x1_act", 32'(x_act[DT_IDX*8 +: 8]), 32'd0);

    // Done/irq with simultaneous STATUS read
    bus_write(8'h01, 8'h20);
    check_output("irq_before", 32'(irq), 32'd0);
    @(negedge clk); valid = 1'b1; cs = 1'b1; rd = 1'b1; addr = 8'h00;
    @(negedge clk); valid = 1'b0; cs = 1'b0; rd = 1'b0;
    check_output("done_race_rdata", 32'(rdata), 32'h00);
    check_output("done_race_irq", 32'(irq), 32'd1);
    read_check("done_status", 8'h00, 8'h02);
    check_output("irq_cleared", 32'(irq), 32'd0);
    read_check("done_cleared", 8'h00, 8'h00);

    // Reset in the middle of a sequence
    bus_write(8'h81, 8'h99);
    @(negedge clk); cs = 1'b1; wr = 1'b1; addr = 8'h01; wdata = 8'h19;
    @(posedge clk); #1; cs = 1'b0; wr = 1'b0;
    check_output("mid_init", 32'(init_pulse), 32'd1);
    check_output("mid_g1", 32'(g_act[15:8]), 32'h99);
    #2 rst_n = 1'b0;
    #1;
    check_output("mid_rst_init", 32'(init_pulse), 32'd0);
    check_output("mid_rst_start", 32'(start_pulse), 32'd0);
    check_output("mid_rst_g1", 32'(g_act[15:8]), 32'(g_default(1)));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_output("post_rst_start", 32'(start_pulse), 32'd0);
    reset_model();
    read_check("post_rst_g1_shadow", 8'h81, g_default(1));

    // Randomized traffic against the model
    for (int it = 0; it < 80; it++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 3) begin
        a = pick_addr(int'($urandom_range(0, 4)));
        d = 8'($urandom);
        bus_write(8'(a), d);
        if (a >= 8 && a < 8 + N_IN) begin
          if (!(a - 8 == DT_IDX && m_dt_sh)) m_x_sh[a-8] = d;
        end else if (a >= 16 && a < 16 + N_MF) m_mf_sh[a-16] = d;
        else if (a >= 128 && a < 128 + N_RULE) m_g_sh[a-128] = d;
        else if (a >= 240 && a < 243) m_est_sh[a-240] = d;
        else m_addr = 1'b1;
      end else if (op <= 6) begin
        case ($urandom_range(0, 2))
          0: a = 0;
          1: a = pick_addr(int'($urandom_range(0, 4)));
          default: a = int'($urandom_range(0, 255));
        endcase
        read_check("rnd_read", 8'(a), exp_read(a));
        if (a == 0) begin m_done = 1'b0; m_ovr = 1'b0; m_addr = 1'b0; end
      end else if (op == 7) begin
        @(negedge clk); valid = 1'b1;
        @(negedge clk); valid = 1'b0;
        m_done = 1'b1;
      end else begin
        d = 8'h10 | (8'($urandom) & 8'h27);
        bus_write(8'h01, d);
        m_rm_sh = d[1]; m_dt_sh = d[2]; m_ie = d[5];
        m_x_ar = m_x_sh; m_mf_ar = m_mf_sh; m_g_ar = m_g_sh; m_est_ar = m_est_sh;
        m_rm_ar = d[1]; m_dt_ar = d[2];
        check_active("rnd_commit");
      end
      check_output("rnd_irq", 32'(irq), 32'(m_done & m_ie));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
